// File: rtl/floating_point_ln.sv
// -----------------------------------------------------------------------------
// floating_point_ln
//
// Sequential natural logarithm of an IEEE-754 single-precision operand.
// The result is a signed Q8.24 fixed-point value. This is the inverse of the
// exp stage in the NN datapath.
//
// Method: shift-and-add multiplicative normalisation.
//   x = 2^e * m, with m in [1,2).
//   M starts at m. At each step k = 1..ITER it is multiplied by (1 + 2^-k)
//   whenever the product stays below 2.0. The matching ln(1 + 2^-k) terms are
//   summed into ACC. When the loop ends, M is very close to 2, so
//   ln(m) ~= ln2 - ACC and ln(x) = e*ln2 + (ln2 - ACC).
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous, active-low reset
//   in_valid   in   1   operand x is valid
//   in_ready   out  1   block can accept an operand (high only when idle)
//   x          in   32  IEEE-754 single operand
//   out_valid  out  1   res and flags valid; held until out_ready
//   out_ready  in   1   consumer accepts the result
//   res        out  32  ln(x), signed Q8.24 two's complement
//   err_nan    out  1   x negative (not -0), NaN or -inf
//   err_zero   out  1   x is +/-0 or subnormal
// -----------------------------------------------------------------------------
module floating_point_ln #(
  parameter int ITER = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        err_nan,
  output logic        err_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0]        LAST_K = 5'(ITER);
  localparam logic signed [31:0] LN2   = 32'sh00B17218;

  // round(ln(1 + 2^-k) * 2^24). For k >= 13 this is exactly 2^(24-k).
  function automatic logic [23:0] lutLn(input logic [4:0] k);
    logic [23:0] v;
    case (k)
      5'd1:    v = 24'd6802576;
      5'd2:    v = 24'd3743728;
      5'd3:    v = 24'd1976071;
      5'd4:    v = 24'd1017112;
      5'd5:    v = 24'd516263;
      5'd6:    v = 24'd260117;
      5'd7:    v = 24'd130563;
      5'd8:    v = 24'd65408;
      5'd9:    v = 24'd32736;
      5'd10:   v = 24'd16376;
      5'd11:   v = 24'd8190;
      5'd12:   v = 24'd4096;
      5'd13:   v = 24'd2048;
      5'd14:   v = 24'd1024;
      5'd15:   v = 24'd512;
      5'd16:   v = 24'd256;
      5'd17:   v = 24'd128;
      5'd18:   v = 24'd64;
      5'd19:   v = 24'd32;
      5'd20:   v = 24'd16;
      5'd21:   v = 24'd8;
      5'd22:   v = 24'd4;
      5'd23:   v = 24'd2;
      5'd24:   v = 24'd1;
      default: v = 24'd0;
    endcase
    return v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [29:0]        m_q, m_d;        // unsigned Q2.28 normalised mantissa
  logic [24:0]        acc_q, acc_d;    // sum of accepted LUT terms, Q1.24
  logic [4:0]         k_q, k_d;
  logic signed [7:0]  e_q, e_d;        // unbiased exponent
  logic [31:0]        res_q, res_d;
  logic               errNan_q, errNan_d;
  logic               errZero_q, errZero_d;

  // Trial product M*(1+2^-k). M < 2, so the sum is below 4 and fits Q2.28;
  // bit 29 set means the trial reached 2.0 or more and must be rejected.
  logic [29:0]        tSum;
  logic signed [31:0] eExt, eProd, lnMant, finRes;

  assign tSum   = m_q + (m_q >> k_q);
  assign eExt   = {{24{e_q[7]}}, e_q};
  assign eProd  = eExt * LN2;
  assign lnMant = LN2 - $signed({7'd0, acc_q});
  assign finRes = eProd + lnMant;

  // Operand field decode used when an operand is accepted.
  logic [7:0]  xExp;
  logic [22:0] xFrac;
  logic        xSign;

  assign xSign = x[31];
  assign xExp  = x[30:23];
  assign xFrac = x[22:0];

  // Next-state logic. Special operands skip the iteration and go straight to
  // DONE. Normal operands run ITER CALC steps, then one FIN step.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    k_d       = k_q;
    e_d       = e_q;
    res_d     = res_q;
    errNan_d  = errNan_q;
    errZero_d = errZero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d   = {2'b01, xFrac, 5'd0};
          e_d   = 8'(xExp - 8'd127);
          acc_d = '0;
          k_d   = 5'd1;
          if (xExp == 8'd0) begin
            res_d     = 32'h8000_0000;
            errZero_d = 1'b1;
            state_d   = S_DONE;
          end else if (xSign || (xExp == 8'hFF && xFrac != 23'd0)) begin
            res_d    = 32'h8000_0000;
            errNan_d = 1'b1;
            state_d  = S_DONE;
          end else if (xExp == 8'hFF) begin
            res_d   = 32'h7FFF_FFFF;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!tSum[29]) begin
          m_d   = tSum;
          acc_d = acc_q + {1'b0, lutLn(k_q)};
        end
        k_d = k_q + 5'd1;
        if (k_q == LAST_K) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        // |ln x| < 89 for every normal operand, so no saturation is needed.
        res_d   = finRes;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          errNan_d  = 1'b0;
          errZero_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset aborts any operation in flight without emitting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      e_q       <= '0;
      res_q     <= '0;
      errNan_q  <= 1'b0;
      errZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      e_q       <= e_d;
      res_q     <= res_d;
      errNan_q  <= errNan_d;
      errZero_q <= errZero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign err_nan   = errNan_q;
  assign err_zero  = errZero_q;

endmodule
